seg_display_mux: RTL and testbench

Parametrised multiplexed seven-segment driver for the Stacker board display. It generalises the fixed level readout to any binary value of `VALUE_W` bits shown across `DIGITS` digits. A sequential double-dabble converter turns the binary value into BCD, and a refresh counter scans the common-anode digits. It also provides leading-zero blanking, an overflow indication, and an optional blink mode. It sits between game logic (level, score, speed) and the board's `segment`/`an` pins.

---
 rtl/seg_display_mux.sv | 198 +++++++++++++++++++
 tb/tb_seg_display_mux.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_mux.sv
// seg_display_mux: multiplexed seven-segment driver for an unsigned binary value.
// A sequential double-dabble converter feeds the display digit registers, and a
// free-running scan counter walks the common-anode digits. Leading zeros are
// blanked, and out-of-range values show dashes with ovf raised.
// Optional feature: define SEG_BLINK_EN to enable the anode blink mode.
module seg_display_mux #(
    parameter int DIGITS    = 4,
    parameter int VALUE_W   = 14,
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    input  logic               blink,
    output logic               busy,
    output logic               ovf,
    output logic [7:0]         segment,
    output logic [DIGITS-1:0]  an
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(VALUE_W + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Conversion controller state; state is the probe point for checkers.
    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;
    state_t state, state_next;

    logic [VALUE_W-1:0] bin_sr;
    logic [BCD_W-1:0]   bcd_acc;
    logic [BCD_W-1:0]   bcd_adj;
    logic               carry_seen;
    logic [CNT_W-1:0]   iter;
    logic [3:0]         disp [DIGITS];
    logic [SCAN_W-1:0]  scan_cnt;
    logic [IDX_W-1:0]   digit_idx;
    logic [DIGITS-1:0]  lit;
    logic [DIGITS-1:0]  an_next;
    logic [7:0]         seg_next;
    logic               blank_all;

    // Active-low gfedcba pattern for one BCD digit, dp off.
    function automatic logic [7:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 8'hC0;
            4'd1:    decode = 8'hF9;
            4'd2:    decode = 8'hA4;
            4'd3:    decode = 8'hB0;
            4'd4:    decode = 8'h99;
            4'd5:    decode = 8'h92;
            4'd6:    decode = 8'h82;
            4'd7:    decode = 8'hF8;
            4'd8:    decode = 8'h80;
            4'd9:    decode = 8'h90;
            default: decode = 8'hFF;
        endcase
    endfunction

    // busy covers both the shifting steps and the commit cycle.
    assign busy = (state != IDLE);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state: load only accepted in IDLE, so loads while busy are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = CONVERT;
            CONVERT: if (iter == CNT_W'(1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every nibble that is 5 or more.
    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
            else                           bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4];
        end
    end

    // Conversion datapath and display registers; any bit shifted out of the
    // top nibble means the value needs more digits than we have.
    always_ff @(posedge clock) begin
        if (reset) begin
            bin_sr     <= '0;
            bcd_acc    <= '0;
            carry_seen <= 1'b0;
            iter       <= '0;
            ovf        <= 1'b0;
            for (int i = 0; i < DIGITS; i++) disp[i] <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr     <= value;
                        bcd_acc    <= '0;
                        carry_seen <= 1'b0;
                        iter       <= CNT_W'(VALUE_W);
                    end
                end
                CONVERT: begin
                    bcd_acc    <= {bcd_adj[BCD_W-2:0], bin_sr[VALUE_W-1]};
                    carry_seen <= carry_seen | bcd_adj[BCD_W-1];
                    bin_sr     <= bin_sr << 1;
                    iter       <= iter - CNT_W'(1);
                end
                COMMIT: begin
                    if (carry_seen) begin
                        ovf <= 1'b1;
                    end else begin
                        ovf <= 1'b0;
                        for (int i = 0; i < DIGITS; i++) disp[i] <= bcd_acc[4*i +: 4];
                    end
                end
                default: ;
            endcase
        end
    end

    // Scan counter: digit index advances once per SCAN_DIV cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == IDX_W'(DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;

    // Blink timebase: runs only while blink is requested, restarts dark-phase-last.
    always_ff @(posedge clock) begin
        if (reset || !blink) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

    assign blank_all = blink & blink_phase;
`else
    logic blink_unused;
    assign blink_unused = blink;
    assign blank_all    = 1'b0;
`endif

    // Digit lighting: a digit is lit if it or any higher digit is nonzero,
    // digit 0 always, and every digit while dashes are shown.
    always_comb begin
        logic seen;
        seen     = ovf;
        lit      = '0;
        an_next  = '1;
        seg_next = 8'hFF;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            seen   = seen | (disp[i] != 4'd0);
            lit[i] = seen | (i == 0);
        end
        if (lit[digit_idx]) begin
            an_next[digit_idx] = 1'b0;
            seg_next           = ovf ? 8'hBF : decode(disp[digit_idx]);
        end
        if (blank_all) an_next = '1;
    end

    // Registered pin drivers.
    always_ff @(posedge clock) begin
        if (reset) begin
            an      <= '1;
            segment <= 8'hFF;
        end else begin
            an      <= an_next;
            segment <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: directed plus randomized bench for seg_display_mux.
// Expected pins come from decimal arithmetic on the last committed value and
// from cycle counts since reset; SEG_BLINK_EN selects the blink expectation.
module tb_seg_display_mux;

    localparam int DIGITS    = 4;
    localparam int VALUE_W   = 14;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 8;

    logic               clock;
    logic               reset;
    logic [VALUE_W-1:0] value;
    logic               load;
    logic               blink;
    logic               busy;
    logic               ovf;
    logic [7:0]         segment;
    logic [DIGITS-1:0]  an;

    seg_display_mux #(
        .DIGITS(DIGITS), .VALUE_W(VALUE_W), .SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clock(clock), .reset(reset), .value(value), .load(load), .blink(blink),
        .busy(busy), .ovf(ovf), .segment(segment), .an(an)
    );

    // Clock and reset block.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [7:0] dec_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    // Reference model state.
    logic [VALUE_W-1:0] exp_q [$];
    int   k          = 0;   // edges since reset released
    int   bm         = 0;   // consecutive edges with blink high
    int   shown_val  = 0;
    bit   shown_dash = 0;
    bit   exp_busy   = 0;
    bit   exp_ovf    = 0;

    function automatic int p10(input int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock edge, then compare every output against the model.
    task automatic tick();
        logic rst_e;
        int   idx, d;
        bit   is_lit;
        logic [DIGITS-1:0] e_an;
        logic [7:0]        e_seg;
        rst_e = reset;
        @(posedge clock);
        #1;
        if (rst_e) begin
            k = 0; bm = 0; shown_val = 0; shown_dash = 0;
            exp_busy = 0; exp_ovf = 0;
            exp_q.delete();
            check("rst_an", 32'(an), 32'hF);
            check("rst_seg", 32'(segment), 32'hFF);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_ovf", 32'(ovf), 32'd0);
        end else begin
            k++;
            if (blink) bm++; else bm = 0;
            idx = ((k - 1) / SCAN_DIV) % DIGITS;
            if (shown_dash) begin
                is_lit = 1;
                e_seg  = 8'hBF;
            end else begin
                d      = (shown_val / p10(idx)) % 10;
                is_lit = (idx == 0) || (shown_val >= p10(idx));
                e_seg  = is_lit ? dec_tab[d] : 8'hFF;
            end
            e_an = is_lit ? ~(DIGITS'(1) << idx) : '1;
`ifdef SEG_BLINK_EN
            if (blink && bm > 0 && (((bm - 1) / BLINK_DIV) % 2) == 1) e_an = '1;
`endif
            check("an", 32'(an), 32'(e_an));
            check("segment", 32'(segment), 32'(e_seg));
            check("busy", 32'(busy), 32'(exp_busy));
            check("ovf", 32'(ovf), 32'(exp_ovf));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Driver: one accepted load, optionally with an ignored load mid-conversion.
    task automatic do_load(input int v, input bit reload);
        logic [VALUE_W-1:0] cv;
        cv = '0;
        value = VALUE_W'(v);
        load = 1'b1;
        exp_busy = 1;
        exp_q.push_back(VALUE_W'(v));
        tick();
        load = 1'b0;
        for (int i = 1; i <= VALUE_W + 1; i++) begin
            if (i == VALUE_W + 1) begin
                cv = exp_q.pop_front();
                exp_busy = 0;
                exp_ovf = (int'(cv) > p10(DIGITS) - 1);
            end
            tick();
            if (reload && i == 3) begin
                value = VALUE_W'($urandom_range(0, (1 << VALUE_W) - 1));
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
            if (i == VALUE_W + 1) begin
                shown_val  = int'(cv);
                shown_dash = exp_ovf;
            end
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; blink = 1'b0; value = '0;
        tick(); tick();
        reset = 1'b0;
        // Idle after reset: only digit 0 lit with "0".
        idle(2 * SCAN_DIV * DIGITS);

        do_load(1234, 0);
        idle(SCAN_DIV * DIGITS + 1);
        do_load(7, 0);
        idle(SCAN_DIV * DIGITS + 1);
        do_load(12000, 0);
        idle(SCAN_DIV * DIGITS + 1);
        // Second load 3 cycles into conversion is dropped.
        do_load(4321, 1);
        idle(SCAN_DIV * DIGITS + 1);
        // Range boundaries.
        do_load(9999, 0);
        idle(SCAN_DIV * DIGITS);
        do_load(10000, 0);
        idle(SCAN_DIV * DIGITS);
        do_load(0, 0);
        idle(SCAN_DIV * DIGITS);
        do_load((1 << VALUE_W) - 1, 0);
        idle(SCAN_DIV * DIGITS);
        do_load(100, 0);
        idle(SCAN_DIV * DIGITS);

        // Reset mid-conversion, asserted together with load: reset wins.
        value = VALUE_W'(999); load = 1'b1; exp_busy = 1;
        tick();
        load = 1'b0;
        idle(3);
        reset = 1'b1; load = 1'b1;
        tick();
        reset = 1'b0; load = 1'b0;
        idle(2 * SCAN_DIV * DIGITS);

        // Blink request over several half-periods.
        do_load(56, 0);
        blink = 1'b1;
        idle(6 * BLINK_DIV);
        blink = 1'b0;
        idle(SCAN_DIV * DIGITS);
        blink = 1'b1;
        idle(3 * BLINK_DIV + 3);
        blink = 1'b0;

        // Randomized loads, gaps, blink and occasional dropped reloads.
        for (int r = 0; r < 30; r++) begin
            blink = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) do_load($urandom_range(0, 9999), $urandom_range(0, 1));
            else                           do_load($urandom_range(0, (1 << VALUE_W) - 1), $urandom_range(0, 1));
            idle($urandom_range(0, 2 * SCAN_DIV * DIGITS));
        end
        blink = 1'b0;
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
